// File: rtl/alu_ctrl_encoder.sv
// rtl/alu_ctrl_encoder.sv - sequences ALU ops into registered control words and a tracked carry
module alu_ctrl_encoder #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [CNT_W-1:0] req_cnt,
  input  logic             flush,
  input  logic             alu_cout,
  output logic [5:0]       ctrl,
  output logic             alu_en,
  output logic             c_flag,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] load_cnt;
  logic [5:0]       ctrl_q, ctrl_d;
  logic             alu_en_q, alu_en_d;
  logic             c_flag_q, c_flag_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;

  // Bit i of the returned word is Ctrl i.
  function automatic logic [5:0] code(input logic [3:0] op);
    case (op)
      4'd0:    code = 6'b010010;
      4'd1:    code = 6'b100010;
      4'd2:    code = 6'b010100;
      4'd3:    code = 6'b001100;
      4'd4:    code = 6'b011100;
      4'd5:    code = 6'b011000;
      4'd6:    code = 6'b000000;
      4'd7:    code = 6'b110110;
      4'd8:    code = 6'b000110;
      4'd9:    code = 6'b001001;
      4'd10:   code = 6'b000001;
      4'd11:   code = 6'b010001;
      4'd12:   code = 6'b001101;
      4'd13:   code = 6'b000101;
      4'd14:   code = 6'b010101;
      default: code = 6'b000000;
    endcase
  endfunction

  assign load_cnt = (req_op >= 4'd9) ? req_cnt : CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rem_d    = rem_q;
    c_flag_d = c_flag_q;
    ctrl_d   = 6'b000000;
    alu_en_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    ready_d  = 1'b0;
    // The carry of a step is captured even when that step is being flushed.
    if (alu_en_q) c_flag_d = alu_cout;
    if (flush) begin
      state_d = IDLE;
      ready_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          ready_d = 1'b1;
          if (req_valid && ready_q) begin
            op_d    = req_op;
            ready_d = 1'b0;
            if (req_op == 4'd15) begin
              state_d = DONE;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end else if (load_cnt == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d  = STEP;
              rem_d    = load_cnt;
              alu_en_d = 1'b1;
              ctrl_d   = code(req_op);
            end
          end
        end
        STEP: begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            alu_en_d = 1'b1;
            ctrl_d   = code(op_q);
          end
        end
        DONE: begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= 4'd0;
      rem_q    <= '0;
      c_flag_q <= 1'b0;
      ctrl_q   <= 6'b000000;
      alu_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
      c_flag_q <= c_flag_d;
      ctrl_q   <= ctrl_d;
      alu_en_q <= alu_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign ctrl      = ctrl_q;
  assign alu_en    = alu_en_q;
  assign c_flag    = c_flag_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_ctrl_encoder.sv
// tb/tb_alu_ctrl_encoder.sv - directed self-checking bench for alu_ctrl_encoder
module tb_alu_ctrl_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic [3:0] req_cnt;
  logic       flush;
  logic       alu_cout;
  logic [5:0] ctrl;
  logic       alu_en;
  logic       c_flag;
  logic       done;
  logic       err;

  int n_vec = 0;
  int n_err = 0;

  // Control words written in Ctrl0..Ctrl5 reading order (leftmost = Ctrl0).
  logic [5:0] tbl [15];

  always #5 clk = ~clk;

  alu_ctrl_encoder #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_cnt(req_cnt), .flush(flush), .alu_cout(alu_cout),
    .ctrl(ctrl), .alu_en(alu_en), .c_flag(c_flag), .done(done), .err(err)
  );

  function automatic logic [5:0] rev6(input logic [5:0] s);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = s[5-i];
    return r;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic done_seen;
    tbl = '{6'b010010, 6'b010001, 6'b001010, 6'b001100, 6'b001110,
            6'b000110, 6'b000000, 6'b011011, 6'b011000, 6'b100100,
            6'b100000, 6'b100010, 6'b101100, 6'b101000, 6'b101010};
    rst_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_cnt = 4'd0;
    flush = 1'b0; alu_cout = 1'b0;
    repeat (2) @(negedge clk);
    chk6("rst_ctrl", ctrl, 6'b000000);
    chk1("rst_alu_en", alu_en, 1'b0);
    chk1("rst_c_flag", c_flag, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_ready", req_ready, 1'b1);
    rst_n = 1'b1;

    // ADD then SUB with req_valid held high
    @(negedge clk); req_valid = 1'b1; req_op = 4'd0;
    @(negedge clk);
    chk1("add_alu_en", alu_en, 1'b1);
    chk6("add_ctrl", ctrl, rev6(tbl[0]));
    chk1("add_ready", req_ready, 1'b0);
    req_op = 4'd1;
    @(negedge clk);
    chk1("add_done", done, 1'b1);
    chk1("add_done_alu_en", alu_en, 1'b0);
    chk6("add_done_ctrl", ctrl, 6'b000000);
    chk1("add_done_ready", req_ready, 1'b0);
    @(negedge clk);
    chk1("add_ready_back", req_ready, 1'b1);
    chk1("add_done_clr", done, 1'b0);
    @(negedge clk);
    chk1("sub_alu_en", alu_en, 1'b1);
    chk6("sub_ctrl", ctrl, rev6(tbl[1]));
    req_valid = 1'b0;
    @(negedge clk);
    chk1("sub_done", done, 1'b1);
    chk1("sub_alu_en_off", alu_en, 1'b0);
    @(negedge clk);
    chk1("sub_ready", req_ready, 1'b1);

    // SLL cnt=3 with carries 1,0,1
    req_valid = 1'b1; req_op = 4'd10; req_cnt = 4'd3; alu_cout = 1'b1;
    @(negedge clk);
    chk1("sll_s1_en", alu_en, 1'b1);
    chk6("sll_s1_ctrl", ctrl, rev6(tbl[10]));
    req_valid = 1'b0;
    @(negedge clk);
    chk1("sll_s2_en", alu_en, 1'b1);
    chk1("sll_c1", c_flag, 1'b1);
    alu_cout = 1'b0;
    @(negedge clk);
    chk1("sll_s3_en", alu_en, 1'b1);
    chk6("sll_s3_ctrl", ctrl, rev6(tbl[10]));
    chk1("sll_c2", c_flag, 1'b0);
    alu_cout = 1'b1;
    @(negedge clk);
    chk1("sll_done", done, 1'b1);
    chk1("sll_en_off", alu_en, 1'b0);
    chk1("sll_c3", c_flag, 1'b1);
    @(negedge clk);
    chk1("sll_ready", req_ready, 1'b1);

    // SRA with a zero count bypasses STEP
    req_valid = 1'b1; req_op = 4'd12; req_cnt = 4'd0; alu_cout = 1'b0;
    @(negedge clk);
    chk1("sra0_done", done, 1'b1);
    chk1("sra0_alu_en", alu_en, 1'b0);
    chk1("sra0_err", err, 1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    chk1("sra0_ready", req_ready, 1'b1);
    chk1("sra0_c_flag", c_flag, 1'b1);

    // Illegal op
    req_valid = 1'b1; req_op = 4'd15; req_cnt = 4'd7;
    @(negedge clk);
    chk1("ill_done", done, 1'b1);
    chk1("ill_err", err, 1'b1);
    chk1("ill_alu_en", alu_en, 1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    chk1("ill_ready", req_ready, 1'b1);
    chk1("ill_err_clr", err, 1'b0);
    chk1("ill_c_flag", c_flag, 1'b1);

    // Sweep legal ops with cnt=1
    for (int i = 0; i < 15; i++) begin
      req_valid = 1'b1; req_op = 4'(i); req_cnt = 4'd1;
      @(negedge clk);
      chk6($sformatf("sweep_ctrl_op%0d", i), ctrl, rev6(tbl[i]));
      chk1($sformatf("sweep_en_op%0d", i), alu_en, 1'b1);
      req_valid = 1'b0;
      @(negedge clk);
      chk1($sformatf("sweep_done_op%0d", i), done, 1'b1);
      @(negedge clk);
    end

    // Flush in IDLE blocks an accept
    alu_cout = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd0; flush = 1'b1;
    @(negedge clk);
    chk1("idle_flush_ready", req_ready, 1'b1);
    chk1("idle_flush_en", alu_en, 1'b0);
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk1("idle_flush_en2", alu_en, 1'b0);

    // ROL cnt=15 flushed on the edge that would start step 7
    req_valid = 1'b1; req_op = 4'd11; req_cnt = 4'd15;
    for (int s = 1; s <= 6; s++) begin
      @(negedge clk);
      chk1($sformatf("rol_en_s%0d", s), alu_en, 1'b1);
      req_valid = 1'b0;
      alu_cout = (s % 2 == 1);
      if (s == 6) flush = 1'b1;
    end
    @(negedge clk);
    chk1("rol_flush_en", alu_en, 1'b0);
    chk1("rol_flush_ready", req_ready, 1'b1);
    chk1("rol_flush_done", done, 1'b0);
    chk1("rol_flush_c_flag", c_flag, 1'b0);
    chk6("rol_flush_ctrl", ctrl, 6'b000000);
    flush = 1'b0;
    @(negedge clk);
    chk1("rol_after_done", done, 1'b0);
    chk1("rol_after_en", alu_en, 1'b0);

    // Reset during the second ROR step
    req_valid = 1'b1; req_op = 4'd14; req_cnt = 4'd5; alu_cout = 1'b1;
    @(negedge clk);
    chk1("ror_s1_en", alu_en, 1'b1);
    req_valid = 1'b0;
    @(negedge clk);
    chk1("ror_s2_c_flag", c_flag, 1'b1);
    rst_n = 1'b0;
    #1;
    chk6("ror_rst_ctrl", ctrl, 6'b000000);
    chk1("ror_rst_en", alu_en, 1'b0);
    chk1("ror_rst_c_flag", c_flag, 1'b0);
    chk1("ror_rst_ready", req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    chk1("ror_rst_no_done", done_seen, 1'b0);
    chk1("ror_rst_idle_ready", req_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
